// File: rtl/digger_pkg.sv
// rtl/digger_pkg.sv - shared widths, arbiter state encoding and tile codes for the digger game logic
package digger_pkg;

   localparam int TILE_W = 4;
   localparam int MAP_AW = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_ACK   = 2'd3
   } arb_state_e;

   // Tile-map codes written by the requesters
   localparam logic [TILE_W-1:0] TILE_EMPTY = 4'h0;
   localparam logic [TILE_W-1:0] TILE_DIRT  = 4'h1;
   localparam logic [TILE_W-1:0] TILE_GEM   = 4'h2;
   localparam logic [TILE_W-1:0] TILE_BAG   = 4'h3;

endpackage

// File: rtl/vgaram_arbiter_rr_pick.sv
// rtl/vgaram_arbiter_rr_pick.sv - combinational round-robin picker, searching from last+1 modulo NREQ
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
      if (p == IW'(NREQ - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   logic [IW-1:0] pos;
   logic          found;

   always_comb begin
      grant = '0;
      idx   = last;
      found = 1'b0;
      pos   = last;
      for (int k = 0; k < NREQ; k++) begin
         pos = wrap_inc(pos);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/vgaram_arbiter.sv
// rtl/vgaram_arbiter.sv - round-robin arbiter running atomic read/write transactions on the tile-map RAM port
module vgaram_arbiter
   import digger_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int RD_LAT = 1
) (
   input  logic                     clk100m,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*MAP_AW-1:0]   req_addr,
   input  logic [NREQ*TILE_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          ack,
   output logic [TILE_W-1:0]        rdata,
   output logic                     busy,
   output logic                     vgaram_we,
   output logic [MAP_AW-1:0]        vgaram_addra,
   output logic [TILE_W-1:0]        vgaram_dina,
   input  logic [TILE_W-1:0]        vgaram_douta
);

   localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
   localparam logic [1:0]    CNT_INIT = 2'(RD_LAT - 1);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                op_we_q, op_we_d;
   logic [MAP_AW-1:0]   op_addr_q, op_addr_d;
   logic [TILE_W-1:0]   op_wdata_q, op_wdata_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic [TILE_W-1:0]   rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                ram_we_q, ram_we_d;
   logic [MAP_AW-1:0]   ram_addr_q, ram_addr_d;
   logic [TILE_W-1:0]   ram_dina_q, ram_dina_d;

   logic [NREQ-1:0]     pick_grant;
   logic [IW-1:0]       pick_idx;
   logic                sel_we;
   logic [MAP_AW-1:0]   sel_addr;
   logic [TILE_W-1:0]   sel_wdata;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // One-hot mux of the winning requester's operation
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*MAP_AW +: MAP_AW];
            sel_wdata = req_wdata[i*TILE_W +: TILE_W];
         end
      end
   end

   // RAM-side outputs are registered from the current state, so they trail it by one
   // cycle; the ACK state therefore lines up with the RD_LAT-th read data cycle.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      op_we_d    = op_we_q;
      op_addr_d  = op_addr_q;
      op_wdata_d = op_wdata_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      rdata_d    = rdata_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_dina_d = ram_dina_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               gnt_d      = pick_grant;
               last_d     = pick_idx;
               op_we_d    = sel_we;
               op_addr_d  = sel_addr;
               op_wdata_d = sel_wdata;
               state_d    = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            ram_addr_d = op_addr_q;
            ram_dina_d = op_wdata_q;
            ram_we_d   = op_we_q;
            if (op_we_q) begin
               state_d = ARB_ACK;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = ARB_ACK;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ARB_ACK: begin
            ack_d = gnt_q;
            if (!op_we_q) begin
               rdata_d = vgaram_douta;
            end
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk100m) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         last_q     <= LAST_RST;
         gnt_q      <= '0;
         op_we_q    <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         cnt_q      <= 2'd0;
         ack_q      <= '0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_dina_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         op_we_q    <= op_we_d;
         op_addr_q  <= op_addr_d;
         op_wdata_q <= op_wdata_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_dina_q <= ram_dina_d;
      end
   end

   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign busy         = busy_q;
   assign vgaram_we    = ram_we_q;
   assign vgaram_addra = ram_addr_q;
   assign vgaram_dina  = ram_dina_q;

endmodule

// File: tb/tb_vgaram_arbiter.sv
// tb/tb_vgaram_arbiter.sv - directed and randomized checks of vgaram_arbiter against a RAM and round-robin model
module tb_vgaram_arbiter;

   localparam int NREQ   = 4;
   localparam int RD_LAT = 1;
   localparam int NTXN   = 6;

   logic                clk100m = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_we;
   logic [NREQ*8-1:0]   req_addr;
   logic [NREQ*4-1:0]   req_wdata;
   logic [NREQ-1:0]     ack;
   logic [3:0]          rdata;
   logic                busy;
   logic                vgaram_we;
   logic [7:0]          vgaram_addra;
   logic [3:0]          vgaram_dina;
   logic [3:0]          vgaram_douta;

   always #5 clk100m = ~clk100m;

   vgaram_arbiter #(
      .NREQ   (NREQ),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk100m      (clk100m),
      .rst          (rst),
      .req          (req),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .ack          (ack),
      .rdata        (rdata),
      .busy         (busy),
      .vgaram_we    (vgaram_we),
      .vgaram_addra (vgaram_addra),
      .vgaram_dina  (vgaram_dina),
      .vgaram_douta (vgaram_douta)
   );

   // Single-port RAM with one clock of read latency, read-before-write
   logic [3:0] mem [256];
   logic [3:0] douta_r;
   always @(posedge clk100m) begin
      if (vgaram_we) mem[vgaram_addra] <= vgaram_dina;
      douta_r <= mem[vgaram_addra];
   end
   assign vgaram_douta = douta_r;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle protocol monitor
   logic       prev_we = 1'b0;
   int         we_cnt  = 0;
   logic [7:0] we_addr_log;
   logic [3:0] we_data_log;
   always @(negedge clk100m) begin
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      chk("we_not_twice", 32'(prev_we & vgaram_we), 32'd0);
      prev_we <= vgaram_we;
      if (vgaram_we) begin
         we_cnt      <= we_cnt + 1;
         we_addr_log <= vgaram_addra;
         we_data_log <= vgaram_dina;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk100m);
   endtask

   task automatic set_req(input int r, input logic w, input logic [7:0] a, input logic [3:0] d);
      req_we[r]           = w;
      req_addr[r*8 +: 8]  = a;
      req_wdata[r*4 +: 4] = d;
      req[r]              = 1'b1;
   endtask

   task automatic run_one(input int r, input logic w, input logic [7:0] a, input logic [3:0] d,
                          output int lat);
      set_req(r, w, a, d);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (ack[r]) begin
            lat = c;
            break;
         end
      end
      req[r] = 1'b0;
      if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic int rr_expect(input int last, input logic [NREQ-1:0] pend);
      for (int k = 1; k <= NREQ; k++) begin
         if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   int         lat, w0, idx, expi, done, model_last, nack, last_ack_cyc, p, cyc;
   logic [3:0] ref_mem [16];
   logic       q_we   [NREQ][NTXN];
   logic [7:0] q_addr [NREQ][NTXN];
   logic [3:0] q_data [NREQ][NTXN];
   int         q_pos  [NREQ];
   logic [NREQ-1:0] pend;
   int         order_exp [5];

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      step();
      step();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(vgaram_we), 32'd0);
      chk("rst_addra", 32'(vgaram_addra), 32'd0);
      chk("rst_dina", 32'(vgaram_dina), 32'd0);
      rst = 1'b0;
      step();

      // Single write from requester 0
      set_req(0, 1'b1, 8'h2A, 4'h3);
      step();
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_we_issue", 32'(vgaram_we), 32'd0);
      step();
      chk("wr_we_pulse", 32'(vgaram_we), 32'd1);
      chk("wr_addra", 32'(vgaram_addra), 32'h2A);
      chk("wr_dina", 32'(vgaram_dina), 32'h3);
      chk("wr_ack_early", 32'(ack), 32'd0);
      step();
      chk("wr_ack3", 32'(ack), 32'b0001);
      chk("wr_we_off", 32'(vgaram_we), 32'd0);
      req[0] = 1'b0;
      step();
      chk("wr_mem", 32'(mem[8'h2A]), 32'h3);

      // Read: store 5 at 10, then requester 2 reads it back
      run_one(3, 1'b1, 8'h10, 4'h5, lat);
      chk("wr_latency", 32'(lat), 32'd3);
      step();
      w0 = we_cnt;
      set_req(2, 1'b0, 8'h10, 4'hF);
      for (int c = 1; c <= 3; c++) begin
         step();
         chk("rd_ack_early", 32'(ack), 32'd0);
      end
      step();
      chk("rd_ack4", 32'(ack), 32'b0100);
      chk("rd_rdata", 32'(rdata), 32'h5);
      req[2] = 1'b0;
      step();
      chk("rd_no_we", 32'(we_cnt), 32'(w0));
      run_one(0, 1'b1, 8'h20, 4'h9, lat);
      chk("rdata_held", 32'(rdata), 32'h5);

      // All four requesters held high from reset
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h40 + i), 4'(i));
      step();
      step();
      rst = 1'b0;
      order_exp = '{0, 1, 2, 3, 0};
      nack = 0;
      last_ack_cyc = -100;
      for (int c = 0; c < 40 && nack < 5; c++) begin
         step();
         if (ack != '0) begin
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (ack[i] && idx < 0) idx = i;
            chk("all4_order", 32'(idx), 32'(order_exp[nack]));
            chk("all4_gap_ge3", 32'(c - last_ack_cyc >= 3), 32'd1);
            last_ack_cyc = c;
            nack++;
            if (nack == 5) req = '0;
         end
      end
      req = '0;
      chk("all4_count", 32'(nack), 32'd5);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("all4_quiet", 32'(ack), 32'd0);
      end

      // Requester 1 drops req (and changes address) during ISSUE
      pulse_rst();
      set_req(1, 1'b1, 8'h50, 4'hA);
      set_req(3, 1'b1, 8'h51, 4'hB);
      step();
      req[1]             = 1'b0;
      req_addr[1*8 +: 8] = 8'hEE;
      step();
      chk("drop_we", 32'(vgaram_we), 32'd1);
      chk("drop_addra", 32'(vgaram_addra), 32'h50);
      chk("drop_dina", 32'(vgaram_dina), 32'hA);
      step();
      chk("drop_ack1", 32'(ack), 32'b0010);
      idx = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (ack != '0) begin
            idx = 32'(ack);
            break;
         end
      end
      chk("drop_next_ack3", 32'(idx), 32'b1000);
      req[3] = 1'b0;
      step();

      // Reset in WAIT aborts the read; first grant afterwards goes to index 0
      set_req(2, 1'b0, 8'h50, 4'h0);
      step();
      step();
      chk("wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_we", 32'(vgaram_we), 32'd0);
      chk("rstw_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      set_req(0, 1'b1, 8'h52, 4'h7);
      idx = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (ack != '0) begin
            idx = 32'(ack);
            break;
         end
      end
      chk("rstw_first_0", 32'(idx), 32'b0001);
      req[0] = 1'b0;
      idx = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (ack != '0) begin
            idx = 32'(ack);
            break;
         end
      end
      chk("rstw_then_2", 32'(idx), 32'b0100);
      chk("rstw_rdata", 32'(rdata), 32'hA);
      req[2] = 1'b0;
      step();

      // Randomized traffic: prefill addresses 0..15, then per-requester queues
      for (int a = 0; a < 16; a++) begin
         ref_mem[a] = 4'($urandom);
         run_one(0, 1'b1, 8'(a), ref_mem[a], lat);
         chk("pre_latency", 32'(lat), 32'd3);
         step();
      end
      pulse_rst();
      model_last = NREQ - 1;
      for (int r = 0; r < NREQ; r++) begin
         for (int t = 0; t < NTXN; t++) begin
            q_we[r][t]   = 1'($urandom);
            q_addr[r][t] = 8'($urandom_range(0, 15));
            q_data[r][t] = 4'($urandom);
         end
         q_pos[r] = 0;
         set_req(r, q_we[r][0], q_addr[r][0], q_data[r][0]);
      end
      w0   = we_cnt;
      done = 0;
      cyc  = 0;
      while (done < NREQ*NTXN && cyc < 3000) begin
         step();
         cyc++;
         if (ack != '0) begin
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (ack[i] && idx < 0) idx = i;
            for (int i = 0; i < NREQ; i++) pend[i] = (q_pos[i] < NTXN);
            expi = rr_expect(model_last, pend);
            chk("rnd_rr_order", 32'(idx), 32'(expi));
            if (idx == expi) begin
               p = q_pos[idx];
               if (q_we[idx][p]) begin
                  chk("rnd_we_addr", 32'(we_addr_log), 32'(q_addr[idx][p]));
                  chk("rnd_we_data", 32'(we_data_log), 32'(q_data[idx][p]));
                  ref_mem[q_addr[idx][p][3:0]] = q_data[idx][p];
               end else begin
                  chk("rnd_rdata", 32'(rdata), 32'(ref_mem[q_addr[idx][p][3:0]]));
               end
               q_pos[idx]++;
               if (q_pos[idx] < NTXN) begin
                  set_req(idx, q_we[idx][q_pos[idx]], q_addr[idx][q_pos[idx]], q_data[idx][q_pos[idx]]);
               end else begin
                  req[idx] = 1'b0;
               end
            end else begin
               req[idx] = 1'b0;
            end
            model_last = idx;
            done++;
         end
      end
      req = '0;
      chk("rnd_all_done", 32'(done), 32'(NREQ*NTXN));
      step();
      step();
      p = 0;
      for (int r = 0; r < NREQ; r++)
         for (int t = 0; t < NTXN; t++) p += int'(q_we[r][t]);
      chk("rnd_we_count", 32'(we_cnt - w0), 32'(p));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
